// File: rtl/col_encoder_param_if.sv
// Pixel-in / encoded-word-out handshake bundle for col_encoder_param.
// master = scanner/packetiser side, slave = encoder side.
interface col_encoder_param_if #(
  parameter int unsigned PIX_W  = 2,
  parameter int unsigned WORD_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [PIX_W-1:0]  pixel_in;
  logic              col_last;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              out_last;

  modport master (
    output in_valid, pixel_in, col_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, pixel_in, col_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/col_encoder_param.sv
// Column encoder: zero runs >= ZERO_TH become run words, other pixels are packed
// into raw words; 2-entry output queue. Optional COL_ENC_STATS_EN adds pop counters.
module col_encoder_param #(
  parameter int unsigned PIX_W   = 2,
  parameter int unsigned WORD_W  = 16,
  parameter int unsigned RAW_N   = 6,
  parameter int unsigned ZERO_TH = 3
) (
  input  logic clk,
  input  logic rst_n,
  col_encoder_param_if.slave bus
`ifdef COL_ENC_STATS_EN
  ,
  output logic [31:0] stat_raw_words,
  output logic [31:0] stat_run_words
`endif
);

  localparam int unsigned CNT_W = $clog2(RAW_N + 1);
  localparam int unsigned BUF_W = RAW_N * PIX_W;
  localparam int unsigned RUN_W = WORD_W - 1;
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  localparam logic [CNT_W-1:0] TH_C    = CNT_W'(ZERO_TH);
  localparam logic [CNT_W-1:0] RAWN_C  = CNT_W'(RAW_N);

  typedef enum logic [1:0] {S_IDLE, S_RAW, S_RUN} state_e;

  state_e                     state_q, state_d;
  logic [BUF_W-1:0]           pix_q, pix_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           tz_q, tz_d;
  logic [RUN_W-1:0]           run_q, run_d;
  logic [1:0][WORD_W-1:0]     qdata_q, qdata_d;
  logic [1:0]                 qlast_q, qlast_d;
  logic [1:0]                 qcnt_q, qcnt_d;

  logic                       accept, pop, is_zero;
  logic [BUF_W-1:0]           pix_n, load_pix;
  logic [CNT_W-1:0]           cnt_n, tz_n, kept;
  logic [RUN_W-1:0]           run_n;
  logic                       v0, v1, l0, l1;
  logic [WORD_W-1:0]          w0, w1;
  logic [1:0]                 qn;

  function automatic logic [WORD_W-1:0] raw_word(input logic [BUF_W-1:0] pix,
                                                 input logic [CNT_W-1:0] k);
    logic [WORD_W-1:0] w;
    logic [BUF_W-1:0]  mask;
    mask = ~({BUF_W{1'b1}} >> (32'(k) * PIX_W));
    w = '0;
    w[WORD_W-1] = 1'b1;
    w[WORD_W-2 -: CNT_W] = k;
    w[BUF_W-1:0] = pix & mask;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] run_word(input logic [RUN_W-1:0] n);
    return {1'b0, n};
  endfunction

  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.in_ready  = (qcnt_q == 2'd0);
  assign bus.out_valid = (qcnt_q != 2'd0);
  assign bus.out_data  = qdata_q[0];
  assign bus.out_last  = qlast_q[0];

  // Unused buffer slots are kept at zero, so appending is a plain OR-in.
  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    cnt_d   = cnt_q;
    tz_d    = tz_q;
    run_d   = run_q;
    v0 = 1'b0;
    v1 = 1'b0;
    l0 = 1'b0;
    l1 = 1'b0;
    w0 = '0;
    w1 = '0;

    is_zero  = (bus.pixel_in == '0);
    pix_n    = pix_q | (BUF_W'(bus.pixel_in) << (BUF_W - PIX_W - 32'(cnt_q) * PIX_W));
    cnt_n    = cnt_q + CNT_W'(1);
    tz_n     = is_zero ? tz_q + CNT_W'(1) : '0;
    kept     = cnt_n - TH_C;
    load_pix = '0;
    load_pix[BUF_W-1 -: PIX_W] = bus.pixel_in;
    run_n    = (run_q == RUN_MAX) ? RUN_W'(1) : run_q + RUN_W'(1);

    if (accept) begin
      if (state_q == S_RUN) begin
        if (is_zero) begin
          if (run_q == RUN_MAX) begin
            v0 = 1'b1;
            w0 = run_word(RUN_MAX);
          end
          run_d = run_n;
          if (bus.col_last) begin
            if (v0) begin
              v1 = 1'b1;
              w1 = run_word(run_n);
              l1 = 1'b1;
            end else begin
              v0 = 1'b1;
              w0 = run_word(run_n);
              l0 = 1'b1;
            end
            run_d   = '0;
            state_d = S_IDLE;
          end
        end else begin
          v0      = 1'b1;
          w0      = run_word(run_q);
          run_d   = '0;
          pix_d   = load_pix;
          cnt_d   = CNT_W'(1);
          tz_d    = '0;
          state_d = S_RAW;
          if (bus.col_last) begin
            v1      = 1'b1;
            w1      = raw_word(load_pix, CNT_W'(1));
            l1      = 1'b1;
            pix_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
      end else begin
        if (tz_n == TH_C) begin
          // Trailing zeros sit in the low slots that raw_word masks off via kept.
          pix_d   = '0;
          cnt_d   = '0;
          tz_d    = '0;
          run_d   = RUN_W'(ZERO_TH);
          state_d = S_RUN;
          if (kept != '0) begin
            v0 = 1'b1;
            w0 = raw_word(pix_n, kept);
          end
          if (bus.col_last) begin
            run_d   = '0;
            state_d = S_IDLE;
            if (kept != '0) begin
              v1 = 1'b1;
              w1 = run_word(RUN_W'(ZERO_TH));
              l1 = 1'b1;
            end else begin
              v0 = 1'b1;
              w0 = run_word(RUN_W'(ZERO_TH));
              l0 = 1'b1;
            end
          end
        end else if (cnt_n == RAWN_C) begin
          v0      = 1'b1;
          w0      = raw_word(pix_n, RAWN_C);
          l0      = bus.col_last;
          pix_d   = '0;
          cnt_d   = '0;
          tz_d    = '0;
          state_d = S_IDLE;
        end else if (bus.col_last) begin
          v0      = 1'b1;
          w0      = raw_word(pix_n, cnt_n);
          l0      = 1'b1;
          pix_d   = '0;
          cnt_d   = '0;
          tz_d    = '0;
          state_d = S_IDLE;
        end else begin
          pix_d   = pix_n;
          cnt_d   = cnt_n;
          tz_d    = tz_n;
          state_d = S_RAW;
        end
      end
    end
  end

  // Pop shifts the head first, then up to two new words land behind what is left.
  always_comb begin
    qdata_d = qdata_q;
    qlast_d = qlast_q;
    qn      = qcnt_q;
    if (pop) begin
      qdata_d[0] = qdata_q[1];
      qlast_d[0] = qlast_q[1];
      qn         = qn - 2'd1;
    end
    if (v0) begin
      qdata_d[qn[0]] = w0;
      qlast_d[qn[0]] = l0;
      qn             = qn + 2'd1;
    end
    if (v1) begin
      qdata_d[qn[0]] = w1;
      qlast_d[qn[0]] = l1;
      qn             = qn + 2'd1;
    end
    qcnt_d = qn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pix_q   <= '0;
      cnt_q   <= '0;
      tz_q    <= '0;
      run_q   <= '0;
      qdata_q <= '0;
      qlast_q <= '0;
      qcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      cnt_q   <= cnt_d;
      tz_q    <= tz_d;
      run_q   <= run_d;
      qdata_q <= qdata_d;
      qlast_q <= qlast_d;
      qcnt_q  <= qcnt_d;
    end
  end

`ifdef COL_ENC_STATS_EN
  logic [31:0] stat_raw_q, stat_raw_d;
  logic [31:0] stat_run_q, stat_run_d;

  always_comb begin
    stat_raw_d = stat_raw_q;
    stat_run_d = stat_run_q;
    if (pop) begin
      if (qdata_q[0][WORD_W-1]) begin
        if (stat_raw_q != '1) stat_raw_d = stat_raw_q + 32'd1;
      end else begin
        if (stat_run_q != '1) stat_run_d = stat_run_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_raw_q <= '0;
      stat_run_q <= '0;
    end else begin
      stat_raw_q <= stat_raw_d;
      stat_run_q <= stat_run_d;
    end
  end

  assign stat_raw_words = stat_raw_q;
  assign stat_run_words = stat_run_q;
`endif

endmodule

// File: tb/tb_col_encoder_param.sv
// Self-checking bench for col_encoder_param: directed columns, saturation,
// backpressure, randomized columns and mid-column reset against a queue model.
module tb_col_encoder_param;
  localparam int PIX_W   = 2;
  localparam int WORD_W  = 16;
  localparam int RAW_N   = 6;
  localparam int ZERO_TH = 3;
  localparam int CNT_W   = $clog2(RAW_N + 1);
  localparam int RUN_MAX = (1 << (WORD_W - 1)) - 1;

  logic clk;
  logic rst_n;

  col_encoder_param_if #(.PIX_W(PIX_W), .WORD_W(WORD_W)) bus();

`ifdef COL_ENC_STATS_EN
  logic [31:0] stat_raw_words;
  logic [31:0] stat_run_words;
`endif

  col_encoder_param #(
    .PIX_W(PIX_W), .WORD_W(WORD_W), .RAW_N(RAW_N), .ZERO_TH(ZERO_TH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef COL_ENC_STATS_EN
    ,
    .stat_raw_words(stat_raw_words),
    .stat_run_words(stat_run_words)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rdy_err = 0;
  int stab_err = 0;
  int to_err = 0;
  int emitted = 0;
  int popped = 0;
  int braw = 0;
  int brun = 0;
  bit rnd_rdy = 1'b0;
  int rdy_pct = 100;
  bit stall_seen = 1'b0;
  bit prev_hold = 1'b0;
  logic [WORD_W-1:0] prev_data;
  logic prev_last;

  logic [WORD_W:0] exp_q[$];
  logic [WORD_W:0] got_q[$];

  int mbuf[$];
  int mrun = 0;
  bit mrunmode = 1'b0;

  function automatic void m_emit(int w);
    logic [WORD_W:0] e;
    e = {1'b0, w[WORD_W-1:0]};
    exp_q.push_back(e);
    emitted++;
  endfunction

  function automatic void m_emit_raw();
    int w;
    w = (1 << (WORD_W - 1)) | (mbuf.size() << (WORD_W - 1 - CNT_W));
    foreach (mbuf[i]) w = w | (mbuf[i] << (PIX_W * (RAW_N - 1 - i)));
    m_emit(w);
  endfunction

  // Reference: pixels collect in a list; trailing zeros are counted by scanning it.
  function automatic void model_beat(int p, bit last);
    int tz;
    logic [WORD_W:0] t;
    if (!mrunmode) begin
      mbuf.push_back(p);
      tz = 0;
      for (int i = mbuf.size() - 1; i >= 0 && mbuf[i] == 0; i--) tz++;
      if (tz == ZERO_TH) begin
        repeat (ZERO_TH) void'(mbuf.pop_back());
        if (mbuf.size() > 0) m_emit_raw();
        mbuf.delete();
        mrunmode = 1'b1;
        mrun = ZERO_TH;
      end else if (mbuf.size() == RAW_N) begin
        m_emit_raw();
        mbuf.delete();
      end
    end else if (p == 0) begin
      if (mrun == RUN_MAX) begin
        m_emit(mrun);
        mrun = 1;
      end else begin
        mrun++;
      end
    end else begin
      m_emit(mrun);
      mrunmode = 1'b0;
      mbuf.delete();
      mbuf.push_back(p);
    end
    if (last) begin
      if (mrunmode) m_emit(mrun);
      else if (mbuf.size() > 0) m_emit_raw();
      mrunmode = 1'b0;
      mbuf.delete();
      mrun = 0;
      if (exp_q.size() > 0) begin
        t = exp_q.pop_back();
        t[WORD_W] = 1'b1;
        exp_q.push_back(t);
      end
    end
  endfunction

  task automatic clear_after_reset();
    mbuf.delete();
    mrunmode = 1'b0;
    mrun = 0;
    emitted = 0;
    popped = 0;
    braw = 0;
    brun = 0;
    prev_hold = 1'b0;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic tick(output bit acc);
    bit pop;
    bit exp_rdy;
    @(negedge clk);
    exp_rdy = (emitted == popped);
    if (rst_n && bus.in_ready !== exp_rdy) rdy_err++;
    if (bus.in_valid && !bus.in_ready) stall_seen = 1'b1;
    if (prev_hold && (bus.out_data !== prev_data || bus.out_last !== prev_last)) stab_err++;
    pop = bus.out_valid && bus.out_ready;
    prev_hold = bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
    prev_last = bus.out_last;
    acc = bus.in_valid && bus.in_ready;
    if (acc) model_beat(int'(bus.pixel_in), bus.col_last);
    if (pop) begin
      got_q.push_back({bus.out_last, bus.out_data});
      popped++;
      if (bus.out_data[WORD_W-1]) braw++;
      else brun++;
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
  endtask

  task automatic send_beat(input int p, input bit last);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.pixel_in = PIX_W'(p);
    bus.col_last = last;
    while (!acc && n < 2000) begin
      tick(acc);
      n++;
    end
    if (!acc) to_err++;
    bus.in_valid = 1'b0;
    bus.col_last = 1'b0;
    bus.pixel_in = '0;
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    while (popped != emitted && n < 5000) begin
      tick(acc);
      n++;
    end
    if (popped != emitted) to_err++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      failures++;
      $display("FAIL reset_out_data got=%h exp=0000", bus.out_data);
    end
    checks++;
    if (bus.out_last !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_last got=%b exp=0", bus.out_last);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_after_reset();
  endtask

  task automatic run_case(input string name, input int px[$], input logic [WORD_W:0] lit[$]);
    exp_q.delete();
    got_q.delete();
    foreach (px[i]) send_beat(px[i], i == px.size() - 1);
    drain();
    checks++;
    if (got_q.size() != lit.size()) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", name, got_q.size(), lit.size());
    end
    for (int i = 0; i < lit.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== lit[i]) begin
        failures++;
        $display("FAIL %s_word[%0d] got=%h exp=%h", name, i,
                 (i < got_q.size()) ? got_q[i] : '0, lit[i]);
      end
    end
  endtask

  task automatic test_known_columns();
    int px[$];
    logic [WORD_W:0] lit[$];
    bus.out_ready = 1'b1;
    px = '{1, 2, 3, 1, 2, 3};
    lit = '{17'h1E6DB};
    run_case("full_raw", px, lit);
    px = '{1, 0, 0, 0, 0, 0, 2};
    lit = '{17'h09400, 17'h00005, 17'h19800};
    run_case("raw_run_raw", px, lit);
    px = '{3, 0, 0};
    lit = '{17'h1BC00};
    run_case("short_tail", px, lit);
    px = '{0, 0, 0};
    lit = '{17'h10003};
    run_case("zero_th_last", px, lit);
  endtask

  task automatic test_saturation();
    exp_q.delete();
    got_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < RUN_MAX + 1; i++) send_beat(0, i == RUN_MAX);
    drain();
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=2", got_q.size());
    end
    checks++;
    if (got_q.size() < 1 || got_q[0] !== 17'h07FFF) begin
      failures++;
      $display("FAIL sat_word0 got=%h exp=07fff", (got_q.size() > 0) ? got_q[0] : '0);
    end
    checks++;
    if (got_q.size() < 2 || got_q[1] !== 17'h10001) begin
      failures++;
      $display("FAIL sat_word1 got=%h exp=10001", (got_q.size() > 1) ? got_q[1] : '0);
    end
  endtask

  task automatic test_backpressure();
    int p;
    exp_q.delete();
    got_q.delete();
    stall_seen = 1'b0;
    bus.out_ready = 1'b0;
    rnd_rdy = 1'b1;
    rdy_pct = 15;
    for (int i = 0; i < 20; i++) begin
      p = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 3));
      send_beat(p, i == 19);
    end
    drain();
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (stall_seen !== 1'b1) begin
      failures++;
      $display("FAIL bp_stall got=%b exp=1", stall_seen);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_word[%0d] got=%h exp=%h", i,
                 (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL bp_hold_stable got=%0d exp=0", stab_err);
    end
  endtask

  task automatic test_random();
    bit acc;
    int len;
    int p;
    bit longrun;
    exp_q.delete();
    got_q.delete();
    rnd_rdy = 1'b1;
    rdy_pct = 60;
    for (int c = 0; c < 30; c++) begin
      len = int'($urandom_range(1, 40));
      longrun = ($urandom_range(0, 4) == 0);
      for (int i = 0; i < len; i++) begin
        if (longrun && i > 0 && i < len - 1) p = 0;
        else p = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) tick(acc);
        send_beat(p, i == len - 1);
      end
    end
    drain();
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rnd_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rnd_word[%0d] got=%h exp=%h", i,
                 (i < got_q.size()) ? got_q[i] : '0, exp_q[i]);
      end
    end
    checks++;
    if (rdy_err != 0) begin
      failures++;
      $display("FAIL in_ready_vs_queue got=%0d bad cycles exp=0", rdy_err);
    end
    checks++;
    if (stab_err != 0) begin
      failures++;
      $display("FAIL rnd_hold_stable got=%0d exp=0", stab_err);
    end
    checks++;
    if (to_err != 0) begin
      failures++;
      $display("FAIL handshake_timeout got=%0d exp=0", to_err);
    end
`ifdef COL_ENC_STATS_EN
    checks++;
    if (stat_raw_words !== 32'(braw)) begin
      failures++;
      $display("FAIL rnd_stat_raw got=%0d exp=%0d", stat_raw_words, braw);
    end
    checks++;
    if (stat_run_words !== 32'(brun)) begin
      failures++;
      $display("FAIL rnd_stat_run got=%0d exp=%0d", stat_run_words, brun);
    end
`endif
  endtask

  task automatic test_reset_mid();
    exp_q.delete();
    got_q.delete();
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) send_beat(0, 1'b0);
    bus.out_ready = 1'b0;
    send_beat(1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready);
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_after_reset();
    bus.out_ready = 1'b1;
    send_beat(1, 1'b0);
    send_beat(2, 1'b1);
    drain();
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL midrst_count got=%0d exp=1", got_q.size());
    end
    checks++;
    if (got_q.size() < 1 || got_q[0] !== 17'h1A600) begin
      failures++;
      $display("FAIL midrst_word got=%h exp=1a600", (got_q.size() > 0) ? got_q[0] : '0);
    end
`ifdef COL_ENC_STATS_EN
    checks++;
    if (stat_raw_words !== 32'd1) begin
      failures++;
      $display("FAIL midrst_stat_raw got=%0d exp=1", stat_raw_words);
    end
    checks++;
    if (stat_run_words !== 32'd0) begin
      failures++;
      $display("FAIL midrst_stat_run got=%0d exp=0", stat_run_words);
    end
`endif
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog sim_time=%0t limit=20000000", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.pixel_in  = '0;
    bus.col_last  = 1'b0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_known_columns();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
